// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - fetch/data request ports and SRAM control pins of sram_arbiter
interface sram_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic [17:0] addr;
  logic        wre;
  logic        oute;
  logic        hb_mask;
  logic        lb_mask;
  logic        chip_en;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
    input  if_rdata, if_ready, d_rdata, d_ready,
    input  addr, wre, oute, hb_mask, lb_mask, chip_en
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
    output if_rdata, if_ready, d_rdata, d_ready,
    output addr, wre, oute, hb_mask, lb_mask, chip_en
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one 16-bit async SRAM between fetch and load/store ports
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed data priority.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clock,
  input  logic          reset,
  sram_arbiter_if.slave bus,
  inout  wire  [15:0]   data
);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_dport;
  logic [16:0]   r_waddr;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [15:0]   r_rlo;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_d_rdata;

  logic          w_grant_d;
  logic          w_any;
  logic          w_g_we;
  logic [16:0]   w_g_waddr;
  logic [3:0]    w_g_be;
  logic [1:0]    w_first;
  logic [1:0]    w_lo_next;
  logic          w_last;
  logic          w_active;
  logic          w_half;
  logic          w_drive;
  logic          w_unused_ok;

  assign w_any = bus.if_req | bus.d_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;
  assign w_grant_d = bus.d_req & (~bus.if_req | ~r_last_d);
`else
  assign w_grant_d = bus.d_req;
`endif

  assign w_g_waddr = w_grant_d ? bus.d_addr[18:2] : bus.if_addr[18:2];
  assign w_g_we    = w_grant_d & bus.d_we;
  assign w_g_be    = w_grant_d ? bus.d_be : 4'hF;
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_lo_next = (r_we && (r_be[3:2] == 2'b00)) ? S_DONE : S_HI;

  // Write halves whose byte-enable pair is empty never touch the SRAM
  always_comb begin
    w_first = S_LO;
    if (w_g_we) begin
      if (w_g_be[1:0] != 2'b00)      w_first = S_LO;
      else if (w_g_be[3:2] != 2'b00) w_first = S_HI;
      else                           w_first = S_DONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dport    <= 1'b0;
      r_waddr    <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rlo      <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_d   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_dport <= w_grant_d;
            r_waddr <= w_g_waddr;
            r_we    <= w_g_we;
            r_wdata <= bus.d_wdata;
            r_be    <= w_g_be;
            r_cnt   <= '0;
            r_state <= w_first;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d <= w_grant_d;
`endif
          end
        end
        S_LO: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= w_lo_next;
            if (!r_we) r_rlo <= data;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HI: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
            if (!r_we) begin
              if (r_dport) r_d_rdata  <= {data, r_rlo};
              else         r_if_rdata <= {data, r_rlo};
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_active = (r_state == S_LO) || (r_state == S_HI);
  assign w_half   = (r_state == S_HI);
  assign w_drive  = w_active & r_we;

  assign bus.addr    = w_active ? {r_waddr, w_half} : 18'd0;
  assign bus.chip_en = ~w_active;
  assign bus.oute    = ~(w_active & ~r_we);
  assign bus.wre     = ~w_drive;
  // Reads enable both byte lanes; writes select lanes from the latched enables
  assign bus.lb_mask = w_drive ? ~r_be[{w_half, 1'b0}] : ~w_active;
  assign bus.hb_mask = w_drive ? ~r_be[{w_half, 1'b1}] : ~w_active;
  assign data        = w_drive ? (w_half ? r_wdata[31:16] : r_wdata[15:0]) : 16'hzzzz;

  assign bus.if_ready = (r_state == S_DONE) & ~r_dport;
  assign bus.d_ready  = (r_state == S_DONE) & r_dport;
  assign bus.if_rdata = r_if_rdata;
  assign bus.d_rdata  = r_d_rdata;

  assign w_unused_ok = ^{bus.if_addr[31:19], bus.if_addr[1:0], bus.d_addr[31:19], bus.d_addr[1:0]};
endmodule
